// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for mem_port_arbiter        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  localparam int MEM_WORD_BYTES = 8;
  localparam int WMASK_W        = 8;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if : IF / LS / memory-side bundle of the arbiter    |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
);
  import mem_arb_pkg::*;

  logic                if_req_i;
  logic [XLEN-1:0]     if_addr_i;
  logic                if_gnt_o;
  logic                if_rvalid_o;
  logic [INST_LEN-1:0] if_rdata_o;
  logic                if_stall_n_o;

  logic                ls_req_i;
  logic                ls_we_i;
  logic [XLEN-1:0]     ls_addr_i;
  logic [XLEN-1:0]     ls_wdata_i;
  logic [WMASK_W-1:0]  ls_wmask_i;
  logic                ls_gnt_o;
  logic                ls_rvalid_o;
  logic [XLEN-1:0]     ls_rdata_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [XLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_wdata_o;
  logic [WMASK_W-1:0]  mem_wmask_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [XLEN-1:0]     mem_rdata_i;

  // Arbiter view.
  modport master (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_n_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  // Pipeline-stage and memory-model view.
  modport slave (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_n_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

`default_nettype wire

// File: rtl/arb_prio_sel.sv
// +----------------------------------------------------------------------+
// | arb_prio_sel : IF/LS winner select; MEM_ARB_RR_EN = round-robin      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       capture,
  output logic       any_req,
  output arb_owner_t winner
);

  assign any_req = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
  arb_owner_t last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_IF;
    end else if (capture) begin
      last_owner <= winner;
    end
  end

  // Under contention the side that lost the previous capture goes next.
  always_comb begin
    winner = OWN_IF;
    if (if_req && ls_req) begin
      winner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (ls_req) begin
      winner = OWN_LS;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, capture, if_req};

  always_comb begin
    winner = ls_req ? OWN_LS : OWN_IF;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one 64-bit memory port between IF and LS   |
// | Option macro     : MEM_ARB_RR_EN (round-robin)   Revision : 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int INST_LEN   = 32,
  parameter int ADDR_ALIGN = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [XLEN-1:0] ADDR_MASK = {{(XLEN-ADDR_ALIGN){1'b1}}, {ADDR_ALIGN{1'b0}}};

  arb_state_t          state;
  arb_owner_t          owner;
  arb_owner_t          winner;
  logic                any_req;
  logic                capture;
  logic                rsp_hit;
  logic                we_q;
  logic                sel_hi;
  logic [XLEN-1:0]     addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [WMASK_W-1:0]  wmask_q;
  logic [INST_LEN-1:0] if_rdata_q;
  logic [XLEN-1:0]     ls_rdata_q;
  logic [INST_LEN-1:0] if_word;

  arb_prio_sel u_prio_sel (
    .clk     (clk),
    .rst     (rst),
    .if_req  (bus.if_req_i),
    .ls_req  (bus.ls_req_i),
    .capture (capture),
    .any_req (any_req),
    .winner  (winner)
  );

  assign capture = (state == IDLE) && any_req;
  assign rsp_hit = (state == RSP) && bus.mem_rvalid_i;
  // Half-word select uses the original addr[2], which alignment drops from addr_q.
  assign if_word = sel_hi ? bus.mem_rdata_i[2*INST_LEN-1:INST_LEN]
                          : bus.mem_rdata_i[INST_LEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      sel_hi     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            owner <= winner;
            state <= REQ;
            if (winner == OWN_LS) begin
              we_q    <= bus.ls_we_i;
              addr_q  <= bus.ls_addr_i & ADDR_MASK;
              sel_hi  <= bus.ls_addr_i[2];
              wdata_q <= bus.ls_wdata_i;
              wmask_q <= bus.ls_we_i ? bus.ls_wmask_i : '0;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= bus.if_addr_i & ADDR_MASK;
              sel_hi  <= bus.if_addr_i[2];
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        REQ: begin
          // A response beat coinciding with the grant is not taken as the response.
          if (bus.mem_gnt_i) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (bus.mem_rvalid_i) begin
            if (owner == OWN_IF) begin
              if_rdata_q <= if_word;
            end else begin
              ls_rdata_q <= bus.mem_rdata_i;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt_o     = capture && (winner == OWN_IF);
  assign bus.ls_gnt_o     = capture && (winner == OWN_LS);
  assign bus.if_rvalid_o  = rsp_hit && (owner == OWN_IF);
  assign bus.ls_rvalid_o  = rsp_hit && (owner == OWN_LS);
  assign bus.if_stall_n_o = bus.if_rvalid_o;
  // Data is presented in the rvalid cycle and then held from the capture register.
  assign bus.if_rdata_o   = bus.if_rvalid_o ? if_word : if_rdata_q;
  assign bus.ls_rdata_o   = bus.ls_rvalid_o ? bus.mem_rdata_i : ls_rdata_q;

  assign bus.mem_req_o    = (state == REQ);
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_wmask_o  = wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench for the arbiter   |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(64), .INST_LEN(32)) bus ();

  mem_port_arbiter #(.XLEN(64), .INST_LEN(32), .ADDR_ALIGN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.ls_req_i     = 1'b0;
    bus.ls_we_i      = 1'b0;
    bus.ls_addr_i    = '0;
    bus.ls_wdata_i   = '0;
    bus.ls_wmask_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req_o); end
    checks++; if (bus.if_stall_n_o !== 1'b0) begin errors++; $display("FAIL reset_stall_n got=%0h exp=0", bus.if_stall_n_o); end
    checks++; if (bus.if_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got=%0h exp=0", bus.if_rdata_o); end
    checks++; if (bus.ls_rdata_o !== 64'h0) begin errors++; $display("FAIL reset_ls_rdata got=%0h exp=0", bus.ls_rdata_o); end
    checks++; if ({bus.mem_addr_o, bus.mem_wmask_o, bus.mem_we_o} !== 73'h0) begin errors++; $display("FAIL reset_mem_fields got=%0h exp=0", {bus.mem_addr_o, bus.mem_wmask_o, bus.mem_we_o}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0004;
    #1;
    checks++; if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got=%b exp=10", {bus.if_gnt_o, bus.ls_gnt_o}); end
    tick();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1;
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL fetch_mem_req got=%0h exp=1", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL fetch_mem_addr got=%0h exp=80000000", bus.mem_addr_o); end
    checks++; if ({bus.mem_we_o, bus.mem_wmask_o} !== 9'h0) begin errors++; $display("FAIL fetch_we_mask got=%0h exp=0", {bus.mem_we_o, bus.mem_wmask_o}); end
    checks++; if (bus.if_stall_n_o !== 1'b0) begin errors++; $display("FAIL fetch_stall_req got=%0h exp=0", bus.if_stall_n_o); end
    tick();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h0010_0093_0000_0013;
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%0h exp=1", bus.if_rvalid_o); end
    checks++; if (bus.if_rdata_o !== 32'h0010_0093) begin errors++; $display("FAIL fetch_rdata got=%0h exp=00100093", bus.if_rdata_o); end
    checks++; if (bus.if_stall_n_o !== 1'b1) begin errors++; $display("FAIL fetch_stall_n got=%0h exp=1", bus.if_stall_n_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_req_in_rsp got=%0h exp=0", bus.mem_req_o); end
    tick();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #1;
    checks++; if ({bus.if_rvalid_o, bus.if_stall_n_o} !== 2'b00) begin errors++; $display("FAIL fetch_after got=%b exp=00", {bus.if_rvalid_o, bus.if_stall_n_o}); end
    checks++; if (bus.if_rdata_o !== 32'h0010_0093) begin errors++; $display("FAIL fetch_rdata_hold got=%0h exp=00100093", bus.if_rdata_o); end
    tick();
  endtask

  task automatic test_contention;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0000;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h0000_0000_8000_1008;
    #1;
    checks++; if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b01) begin errors++; $display("FAIL cont_first_gnt got=%b exp=01", {bus.if_gnt_o, bus.ls_gnt_o}); end
    tick();
    bus.ls_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1;
    checks++; if (bus.mem_addr_o !== 64'h0000_0000_8000_1008) begin errors++; $display("FAIL cont_ls_addr got=%0h exp=80001008", bus.mem_addr_o); end
    checks++; if (bus.if_gnt_o !== 1'b0) begin errors++; $display("FAIL cont_if_gnt_busy got=%0h exp=0", bus.if_gnt_o); end
    tick();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h1122_3344_5566_7788;
    #1;
    checks++; if ({bus.ls_rvalid_o, bus.if_rvalid_o, bus.if_stall_n_o} !== 3'b100) begin errors++; $display("FAIL cont_ls_rvalid got=%b exp=100", {bus.ls_rvalid_o, bus.if_rvalid_o, bus.if_stall_n_o}); end
    checks++; if (bus.ls_rdata_o !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL cont_ls_rdata got=%0h exp=1122334455667788", bus.ls_rdata_o); end
    tick();
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b10) begin errors++; $display("FAIL cont_second_gnt got=%b exp=10", {bus.if_gnt_o, bus.ls_gnt_o}); end
    checks++; if (bus.ls_rdata_o !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL cont_ls_rdata_hold got=%0h exp=1122334455667788", bus.ls_rdata_o); end
    tick();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1;
    checks++; if (bus.mem_addr_o !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL cont_if_addr got=%0h exp=80000000", bus.mem_addr_o); end
    tick();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hCAFE_F00D_DEAD_BEEF;
    #1;
    checks++; if (bus.if_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cont_if_rdata got=%0h exp=deadbeef", bus.if_rdata_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_gnt;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0100;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h0000_0000_8000_2000;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      #1;
      checks++; if ({bus.if_gnt_o, bus.ls_gnt_o} !== exp_gnt) begin errors++; $display("FAIL b2b_gnt_%0d got=%b exp=%b", i, {bus.if_gnt_o, bus.ls_gnt_o}, exp_gnt); end
      tick();
      bus.mem_gnt_i = 1'b1;
      tick();
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
      tick();
      bus.mem_rvalid_i = 1'b0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_store;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 64'h0000_0000_8000_0013;
    bus.ls_wdata_i = 64'h0000_0000_AB00_0000; bus.ls_wmask_i = 8'h08;
    #1;
    checks++; if (bus.ls_gnt_o !== 1'b1) begin errors++; $display("FAIL store_gnt got=%0h exp=1", bus.ls_gnt_o); end
    tick();
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_wmask_i = '0; bus.ls_wdata_i = '0;
    #1;
    checks++; if (bus.mem_addr_o !== 64'h0000_0000_8000_0010) begin errors++; $display("FAIL store_addr got=%0h exp=80000010", bus.mem_addr_o); end
    checks++; if ({bus.mem_we_o, bus.mem_wmask_o} !== 9'h108) begin errors++; $display("FAIL store_we_mask got=%0h exp=108", {bus.mem_we_o, bus.mem_wmask_o}); end
    checks++; if (bus.mem_wdata_o !== 64'h0000_0000_AB00_0000) begin errors++; $display("FAIL store_wdata got=%0h exp=ab000000", bus.mem_wdata_o); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.mem_gnt_i = 1'b1;
      #1;
      checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL store_req_hold_%0d got=%0h exp=1", i, bus.mem_req_o); end
      tick();
    end
    bus.mem_gnt_i = 1'b0;
    #1;
    checks++; if ({bus.mem_req_o, bus.ls_rvalid_o} !== 2'b00) begin errors++; $display("FAIL store_rsp_wait got=%b exp=00", {bus.mem_req_o, bus.ls_rvalid_o}); end
    tick();
    bus.mem_rvalid_i = 1'b1;
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b1) begin errors++; $display("FAIL store_ack got=%0h exp=1", bus.ls_rvalid_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_rsp;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0040;
    tick();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.mem_req_o, bus.mem_we_o, bus.if_stall_n_o} !== 3'b000) begin errors++; $display("FAIL rstrsp_ctl got=%b exp=000", {bus.mem_req_o, bus.mem_we_o, bus.if_stall_n_o}); end
    checks++; if ({bus.if_rdata_o, bus.ls_rdata_o, bus.mem_addr_o} !== 160'h0) begin errors++; $display("FAIL rstrsp_data got=%0h exp=0", {bus.if_rdata_o, bus.ls_rdata_o, bus.mem_addr_o}); end
    tick();
    rst = 1'b0;
    tick();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h1234_5678_9ABC_DEF0;
    #1;
    checks++; if ({bus.if_rvalid_o, bus.ls_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rstrsp_late_rvalid got=%b exp=00", {bus.if_rvalid_o, bus.ls_rvalid_o}); end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0044;
    #1;
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++; $display("FAIL rstrsp_next_gnt got=%0h exp=1", bus.if_gnt_o); end
    tick();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
    #1;
    checks++; if (bus.if_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL rstrsp_next_rdata got=%0h exp=12345678", bus.if_rdata_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_spurious;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++; if ({bus.if_rvalid_o, bus.ls_rvalid_o} !== 2'b00) begin errors++; $display("FAIL spur_idle_rvalid got=%b exp=00", {bus.if_rvalid_o, bus.ls_rvalid_o}); end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h0000_0000_8000_3000;
    tick();
    bus.ls_req_i = 1'b0; bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1;
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b0) begin errors++; $display("FAIL spur_gnt_rvalid got=%0h exp=0", bus.ls_rvalid_o); end
    tick();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if ({bus.mem_req_o, bus.ls_rvalid_o} !== 2'b00) begin errors++; $display("FAIL spur_wait got=%b exp=00", {bus.mem_req_o, bus.ls_rvalid_o}); end
    tick();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h0BAD_F00D_0000_0001;
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b1) begin errors++; $display("FAIL spur_late_rvalid got=%0h exp=1", bus.ls_rvalid_o); end
    checks++; if (bus.ls_rdata_o !== 64'h0BAD_F00D_0000_0001) begin errors++; $display("FAIL spur_rdata got=%0h exp=0badf00d00000001", bus.ls_rdata_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_back_to_back();
    test_store();
    test_reset_in_rsp();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
